// File: rtl/instr_loader.sv
// instr_loader: UART 8N1 program loader that writes big-endian words into instruction memory
// and holds the CPU in reset until the frame completes. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module instr_loader #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
`ifdef LOADER_CHECKSUM_EN
  output logic              chk_err,
`endif
  output logic              frame_err
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {L_HDR_HI, L_HDR_LO, L_WORD, L_CHK, L_DONE} ld_state_t;

  logic              rx_s1, rx_s2, rx_d;
  rx_state_t         rx_state, rx_state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        shreg, shreg_n;
  logic              byte_valid_c, stop_bad_c;

  ld_state_t         ld_state, ld_state_n;
  logic [15:0]       nwords, nwords_n, widx, widx_n, hdr_n_c;
  logic [1:0]        bidx, bidx_n;
  logic [23:0]       wbuf, wbuf_n;
  logic              we_n, done_n, ferr_n, in_range_c;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       wdata_n;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum, sum_n;
  logic              chk_err_n;
`endif

  // Synchronizer plus one edge-detect stage, all idle-high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= R_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      rx_state <= rx_state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    cnt_n        = cnt;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    byte_valid_c = 1'b0;
    stop_bad_c   = 1'b0;
    unique case (rx_state)
      R_IDLE: begin
        cnt_n = '0;
        if (rx_d && !rx_s2) rx_state_n = R_START;
      end
      R_START: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
          cnt_n      = '0;
          bit_idx_n  = '0;
          rx_state_n = rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_n     = '0;
          shreg_n   = {rx_s2, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_n = R_STOP;
        end
      end
      R_STOP: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_n        = '0;
          byte_valid_c = rx_s2;
          stop_bad_c   = !rx_s2;
          rx_state_n   = R_IDLE;
        end
      end
    endcase
  end

  assign hdr_n_c    = {nwords[15:8], shreg};
  assign in_range_c = 32'(widx) < (32'd1 << ADDR_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state   <= L_HDR_HI;
      nwords     <= '0;
      widx       <= '0;
      bidx       <= '0;
      wbuf       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      frame_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
      chk_err    <= 1'b0;
`endif
    end else begin
      ld_state   <= ld_state_n;
      nwords     <= nwords_n;
      widx       <= widx_n;
      bidx       <= bidx_n;
      wbuf       <= wbuf_n;
      imem_we    <= we_n;
      imem_addr  <= addr_n;
      imem_wdata <= wdata_n;
      cpu_hold   <= !done_n;
      done       <= done_n;
      frame_err  <= ferr_n;
`ifdef LOADER_CHECKSUM_EN
      sum        <= sum_n;
      chk_err    <= chk_err_n;
`endif
    end
  end

  always_comb begin
    ld_state_n = ld_state;
    nwords_n   = nwords;
    widx_n     = widx;
    bidx_n     = bidx;
    wbuf_n     = wbuf;
    we_n       = 1'b0;
    addr_n     = imem_addr;
    wdata_n    = imem_wdata;
    done_n     = done;
    ferr_n     = frame_err | stop_bad_c;
`ifdef LOADER_CHECKSUM_EN
    sum_n      = sum;
    chk_err_n  = chk_err;
`endif
    unique case (ld_state)
      L_HDR_HI: if (byte_valid_c) begin
        nwords_n   = {shreg, 8'h00};
        ld_state_n = L_HDR_LO;
      end
      L_HDR_LO: if (byte_valid_c) begin
        nwords_n = hdr_n_c;
        widx_n   = '0;
        bidx_n   = '0;
`ifdef LOADER_CHECKSUM_EN
        sum_n      = '0;
        ld_state_n = (hdr_n_c == 16'd0) ? L_CHK : L_WORD;
`else
        ld_state_n = (hdr_n_c == 16'd0) ? L_DONE : L_WORD;
        done_n     = (hdr_n_c == 16'd0);
`endif
      end
      // Frame end is seen the cycle after the last word's strobe
      L_WORD: begin
        if (widx == nwords) begin
`ifdef LOADER_CHECKSUM_EN
          ld_state_n = L_CHK;
`else
          ld_state_n = L_DONE;
          done_n     = 1'b1;
`endif
        end else if (byte_valid_c) begin
          wbuf_n = {wbuf[15:0], shreg};
          bidx_n = bidx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_n  = sum + shreg;
`endif
          if (bidx == 2'd3) begin
            widx_n = widx + 16'd1;
            if (in_range_c) begin
              we_n    = 1'b1;
              addr_n  = ADDR_W'(widx);
              wdata_n = {wbuf, shreg};
            end
          end
        end
      end
      L_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (byte_valid_c) begin
          if (shreg == sum) begin
            ld_state_n = L_DONE;
            done_n     = 1'b1;
          end else begin
            ld_state_n = L_HDR_HI;
            chk_err_n  = 1'b1;
          end
        end
`else
        ld_state_n = L_HDR_HI;
`endif
      end
      L_DONE: ;
      default: ld_state_n = L_HDR_HI;
    endcase
    // A bad stop bit restarts the session unless the load already finished
    if (stop_bad_c && ld_state != L_DONE) begin
      ld_state_n = L_HDR_HI;
      widx_n     = '0;
      bidx_n     = '0;
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a byte-level frame model predicts memory writes and status flags.
module tb_instr_loader;
  localparam int unsigned CPB = 16;
  localparam int unsigned AW  = 3;

  logic          clk = 1'b0;
  logic          reset, rx;
  logic          imem_we, cpu_hold, done, frame_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic          chk_err;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_we_cyc = -100;
  int done_cyc = -1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t expq[$];

  // Reference model state: header bytes seen, word count, bytes of the word in progress
  int          m_hdr;
  int unsigned m_n, m_idx;
  logic [7:0]  m_wb[$];
  logic [7:0]  m_sum;
  bit          m_done, m_ferr, m_want_chk, m_chkerr, m_last_wr;

  always #5 clk = ~clk;

  instr_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
`ifdef LOADER_CHECKSUM_EN
    .chk_err    (chk_err),
`endif
    .frame_err  (frame_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hdr = 0; m_n = 0; m_idx = 0; m_wb.delete(); m_sum = 8'h00;
    m_done = 0; m_ferr = 0; m_want_chk = 0; m_chkerr = 0; m_last_wr = 0;
    expq.delete();
  endtask

  task automatic finish_words();
`ifdef LOADER_CHECKSUM_EN
    m_want_chk = 1;
`else
    m_done = 1;
`endif
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad);
    wr_t e;
    if (m_done) return;
    if (bad) begin
      m_ferr = 1; m_hdr = 0; m_n = 0; m_idx = 0; m_wb.delete(); m_want_chk = 0;
      return;
    end
    if (m_want_chk) begin
      m_want_chk = 0;
      if (b == m_sum) m_done = 1;
      else begin m_chkerr = 1; m_hdr = 0; m_n = 0; end
      return;
    end
    if (m_hdr < 2) begin
      m_n = (m_n << 8) | 32'(b);
      m_hdr++;
      if (m_hdr == 2) begin
        m_idx = 0; m_sum = 8'h00; m_last_wr = 0;
        if (m_n == 0) finish_words();
      end
      return;
    end
    m_wb.push_back(b);
    m_sum = m_sum + b;
    if (m_wb.size() == 4) begin
      e.addr = AW'(m_idx);
      e.data = {m_wb[0], m_wb[1], m_wb[2], m_wb[3]};
      m_wb.delete();
      m_last_wr = (m_idx < (32'd1 << AW));
      if (m_last_wr) expq.push_back(e);
      m_idx++;
      if (m_idx == m_n) finish_words();
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Bytes go out back-to-back; a bad stop bit is followed by an idle gap
  task automatic send_byte(input logic [7:0] b, input bit bad);
    model_byte(b, bad);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(!bad);
    if (bad) begin
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [31:0] w[$]);
    logic [15:0] n;
    logic [7:0]  bt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  s;
    s = 8'h00;
`endif
    n = 16'(w.size());
    send_byte(n[15:8], 1'b0);
    send_byte(n[7:0], 1'b0);
    foreach (w[i]) begin
      for (int k = 3; k >= 0; k--) begin
        bt = w[i][8*k +: 8];
        send_byte(bt, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        s = s + bt;
`endif
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(s, 1'b0);
`endif
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      rx = ~rx;
      @(negedge clk);
      if (chk) begin
        check("rst imem_we", 32'(imem_we), 0);
        check("rst cpu_hold", 32'(cpu_hold), 1);
        check("rst done", 32'(done), 0);
        check("rst frame_err", 32'(frame_err), 0);
        if (i == 2) begin
          check("rst imem_addr", 32'(imem_addr), 0);
          check("rst imem_wdata", imem_wdata, 0);
        end
      end
    end
    rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    last_we_cyc = -100;
    done_cyc = -1;
  endtask

  task automatic settle(input string tag);
    repeat (20) @(negedge clk);
    check({tag, " done"}, 32'(done), 32'(m_done));
    check({tag, " cpu_hold"}, 32'(cpu_hold), 32'(!m_done));
    check({tag, " frame_err"}, 32'(frame_err), 32'(m_ferr));
    check({tag, " pending_writes"}, 32'(expq.size()), 0);
`ifdef LOADER_CHECKSUM_EN
    check({tag, " chk_err"}, 32'(chk_err), 32'(m_chkerr));
`else
    if (m_done && m_n > 0 && m_last_wr)
      check({tag, " done_latency"}, 32'(done_cyc - last_we_cyc), 1);
`endif
  endtask

  // Monitor: every write strobe must match the head of the expected-write queue
  initial begin
    logic we_prev, done_prev;
    wr_t  e;
    we_prev = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (imem_we === 1'b1) begin
        check("we_single_cycle", 32'(we_prev), 0);
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected", imem_addr, imem_wdata);
        end else begin
          e = expq.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(e.addr));
          check("wr_data", imem_wdata, e.data);
        end
        last_we_cyc = cyc;
      end
      if (done === 1'b1 && !done_prev) done_cyc = cyc;
      we_prev = (imem_we === 1'b1);
      done_prev = (done === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words[$];
    int unsigned n;
    reset = 1'b0;
    rx = 1'b1;
    do_reset(1'b1);

    // Two-word load from the reference example
    words.delete();
    words.push_back(32'h8C010004);
    words.push_back(32'hAC010008);
    send_frame(words);
    settle("two_word");

    // Empty load
    do_reset(1'b0);
    words.delete();
    send_frame(words);
    settle("empty");

    // Short low glitch on idle line must not start a byte
    do_reset(1'b0);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    settle("glitch");
    words.delete();
    words.push_back(32'h12345678);
    send_frame(words);
    settle("after_glitch");

    // Framing error on the 2nd data byte of word 0, then a clean frame
    do_reset(1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b1);
    settle("frame_err");
    words.delete();
    words.push_back(32'hDEADBEEF);
    send_frame(words);
    settle("after_ferr");

    // Reset after 2 of 3 words, then a fresh frame from address 0
    do_reset(1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
    repeat (5) @(negedge clk);
    check("midload_writes", 32'(expq.size()), 0);
    do_reset(1'b1);
    words.delete();
    words.push_back($urandom);
    words.push_back($urandom);
    send_frame(words);
    settle("after_midload");

    // Random frames, first one long enough to overflow the address space
    for (int t = 0; t < 3; t++) begin
      do_reset(1'b0);
      n = (t == 0) ? 10 : $urandom_range(1, 9);
      words.delete();
      for (int i = 0; i < int'(n); i++) words.push_back($urandom);
      send_frame(words);
      settle("random");
    end

`ifdef LOADER_CHECKSUM_EN
    do_reset(1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    settle("chk_ok");
    do_reset(1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    settle("chk_bad");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
